// File: rtl/uart_pkg.sv
// Shared UART types: transmit-arbiter states and receive control points.
package uart_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_HOLD,
        ARB_ISSUE,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request scanning upward from ptr+1.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Walk the ring backwards so the candidate nearest to ptr+1 overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among NUM_REQ clients.
// A winner keeps the transmitter from its first byte through its req_last byte,
// or until it stalls mid-packet for TIMEOUT cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic                        grant_active,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                grant_active_q, grant_active_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State and datapath registers; ptr starts at the top so client 0 wins first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            grant_id_q     <= '0;
            ptr_q          <= IDX_W'(NUM_REQ - 1);
            grant_active_q <= 1'b0;
            last_q         <= 1'b0;
            tx_data_q      <= '0;
            cnt_q          <= '0;
            tx_start_q     <= 1'b0;
            req_ready_q    <= '0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            ptr_q          <= ptr_d;
            grant_active_q <= grant_active_d;
            last_q         <= last_d;
            tx_data_q      <= tx_data_d;
            cnt_q          <= cnt_d;
            tx_start_q     <= tx_start_d;
            req_ready_q    <= req_ready_d;
        end
    end

    // Next-state logic: arbitration, byte capture, frame tracking and stall timeout.
    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        ptr_d          = ptr_q;
        grant_active_d = grant_active_q;
        last_d         = last_q;
        tx_data_d      = tx_data_q;
        cnt_d          = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (!tx_busy && pick_found) begin
                    grant_id_d     = pick_idx;
                    grant_active_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (req_valid[grant_id_q]) begin
                    tx_data_d = req_data[int'(grant_id_q) * DATA_W +: DATA_W];
                    last_d    = req_last[grant_id_q];
                    state_d   = ARB_ISSUE;
                end else if (cnt_q == CNT_LIMIT) begin
                    grant_active_d = 1'b0;
                    ptr_d          = grant_id_q;
                    state_d        = ARB_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_active_d = 1'b0;
                        ptr_d          = grant_id_q;
                        state_d        = ARB_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ARB_HOLD;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Launch pulse and one-hot consume strobe, registered so they coincide with ISSUE.
    always_comb begin
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        if (state_d == ARB_ISSUE) begin
            tx_start_d  = 1'b1;
            req_ready_d = NUM_REQ'(1) << grant_id_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign grant_active = grant_active_q;
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int TOUT  = 8;
   localparam int FRAME = 5;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       gap;
   } expT;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [NREQ-1:0]  reqValid = '0;
   logic [NREQ*DW-1:0] reqData = '0;
   logic [NREQ-1:0]  reqLast = '0;
   logic [NREQ-1:0]  reqReady;
   logic [DW-1:0]    txData;
   logic             txStart;
   logic             txBusy;
   logic             grantActive;
   logic [1:0]       grantId;

   logic             modelBusy = 1'b0;
   logic             busyForce = 1'b0;
   int               busyCnt = 0;
   int               fallCyc = 0;
   int               cyc = 0;
   int               testsRun = 0;
   int               testsFailed = 0;

   logic [8:0]       clientQ [NREQ][$];
   expT              expQ [$];

   assign txBusy = modelBusy | busyForce;

   uart_tx_arbiter #(
      .NUM_REQ (NREQ),
      .DATA_W  (DW),
      .TIMEOUT (TOUT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (reqValid),
      .req_data     (reqData),
      .req_last     (reqLast),
      .req_ready    (reqReady),
      .tx_data      (txData),
      .tx_start     (txStart),
      .tx_busy      (txBusy),
      .grant_active (grantActive),
      .grant_id     (grantId)
   );

   // Free-running clock and posedge cycle counter
   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Counts one comparison and reports it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Queues one packet on a client and records the bytes it must produce, in order
   task automatic applyStimulus(input int id, input logic [7:0] base, input int n, input logic endLast);
      expT e;
      for (int k = 0; k < n; k++) begin
         clientQ[id].push_back({(k == n - 1) ? endLast : 1'b0, base + 8'(k)});
         e.id   = id;
         e.data = base + 8'(k);
         e.gap  = (k > 0);
         expQ.push_back(e);
      end
   endtask

   // Transmitter model: busy for FRAME cycles after each launch
   initial forever begin
      @(negedge clock);
      if (reset) begin
         busyCnt   = 0;
         modelBusy = 1'b0;
      end else if (busyCnt > 0) begin
         busyCnt--;
         if (busyCnt == 0) begin
            modelBusy = 1'b0;
            fallCyc   = cyc;
         end
      end else if (txStart) begin
         busyCnt   = FRAME;
         modelBusy = 1'b1;
      end
   end

   // Client models: present queue head, retire it when req_ready pulses
   initial forever begin
      logic [8:0] head;
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) begin
         if (reqReady[i] && clientQ[i].size() > 0) void'(clientQ[i].pop_front());
         if (clientQ[i].size() > 0) begin
            head = clientQ[i][0];
            reqValid[i]          = 1'b1;
            reqData[i*DW +: DW]  = head[7:0];
            reqLast[i]           = head[8];
         end else begin
            reqValid[i] = 1'b0;
            reqLast[i]  = 1'b0;
         end
      end
   end

   // Monitor: every launch must match the scoreboard head
   initial forever begin
      expT e;
      @(negedge clock);
      if (!reset) begin
         if (reqReady != '0 && !txStart) checkOutput("ready_without_start", 32'(reqReady), 32'd0);
         if (txStart) begin
            checkOutput("start_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checkOutput("tx_data", 32'(txData), 32'(e.data));
               checkOutput("grant_id", 32'(grantId), 32'(e.id));
               checkOutput("req_ready", 32'(reqReady), 32'(1) << e.id);
               checkOutput("grant_active", 32'(grantActive), 32'd1);
               if (e.gap) checkOutput("inter_byte_gap", 32'(cyc - fallCyc), 32'd2);
            end
         end
      end
   end

   // Checks every output against its reset value
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_tx_start"}, 32'(txStart), 32'd0);
      checkOutput({tag, "_req_ready"}, 32'(reqReady), 32'd0);
      checkOutput({tag, "_tx_data"}, 32'(txData), 32'd0);
      checkOutput({tag, "_grant_active"}, 32'(grantActive), 32'd0);
      checkOutput({tag, "_grant_id"}, 32'(grantId), 32'd0);
   endtask

   // Asserts reset, flushes all models and queues, then releases it
   task automatic resetDut();
      @(negedge clock);
      #2;
      reset     = 1'b1;
      busyForce = 1'b0;
      for (int i = 0; i < NREQ; i++) clientQ[i].delete();
      expQ.delete();
      repeat (2) @(negedge clock);
      #1;
      checkResetValues("reset");
      reset = 1'b0;
      @(negedge clock);
      #1;
      checkOutput("no_start_after_reset", 32'(txStart), 32'd0);
   endtask

   // Waits for the scoreboard to empty and the grant to drop, within a budget
   task automatic waitDrain(input string tag);
      logic done = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clock);
         #1;
         if (expQ.size() == 0 && !grantActive && !txBusy) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_drained"}, 32'(done), 32'd1);
   endtask

   // Waits for the last expected byte and returns cycles from busy fall to release
   task automatic waitRelease(output int delta, output logic ok);
      ok = 1'b0;
      delta = -1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clock);
         #1;
         if (expQ.size() == 0 && !grantActive) begin
            ok = 1'b1;
            delta = cyc - fallCyc;
            break;
         end
      end
   endtask

   initial begin
      int   delta;
      int   mark;
      logic ok;

      // Single client, two-byte packet
      resetDut();
      applyStimulus(0, 8'h41, 2, 1'b1);
      waitRelease(delta, ok);
      checkOutput("single_released", 32'(ok), 32'd1);
      checkOutput("single_release_latency", 32'(delta), 32'd1);
      checkOutput("single_grant_id_hold", 32'(grantId), 32'd0);
      waitDrain("single");

      // Contention between clients 0 and 2, three bytes each
      resetDut();
      applyStimulus(0, 8'h10, 3, 1'b1);
      applyStimulus(2, 8'h20, 3, 1'b1);
      waitDrain("contention");

      // Fairness between continuously requesting clients 1 and 3
      resetDut();
      applyStimulus(1, 8'hA0, 1, 1'b1);
      applyStimulus(3, 8'hB0, 1, 1'b1);
      applyStimulus(1, 8'hA1, 1, 1'b1);
      applyStimulus(3, 8'hB1, 1, 1'b1);
      applyStimulus(1, 8'hA2, 1, 1'b1);
      applyStimulus(3, 8'hB2, 1, 1'b1);
      waitDrain("fairness");

      // Timeout: client 1 stalls mid-packet while client 2 waits
      resetDut();
      applyStimulus(1, 8'h50, 1, 1'b0);
      applyStimulus(2, 8'h60, 1, 1'b1);
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clock);
         #1;
         if (expQ.size() == 1 && !grantActive) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("timeout_released", 32'(ok), 32'd1);
      checkOutput("timeout_latency", 32'(cyc - fallCyc), 32'(TOUT + 1));
      checkOutput("timeout_grant_id_hold", 32'(grantId), 32'd1);
      waitDrain("timeout");

      // Busy blocking: no grant while the transmitter is busy
      resetDut();
      busyForce = 1'b1;
      applyStimulus(0, 8'h77, 1, 1'b1);
      repeat (10) @(negedge clock);
      #1;
      checkOutput("busy_blocks_grant", 32'(grantActive), 32'd0);
      @(negedge clock);
      #2;
      busyForce = 1'b0;
      mark = cyc;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         #1;
         if (grantActive) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("busy_grant_seen", 32'(ok), 32'd1);
      checkOutput("busy_grant_latency", 32'(cyc - mark), 32'd1);
      waitDrain("busy");

      // Reset in the middle of a frame, then a fresh contention
      resetDut();
      applyStimulus(2, 8'h30, 2, 1'b1);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         #1;
         if (expQ.size() == 1 && txBusy) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("midframe_reached", 32'(ok), 32'd1);
      repeat (2) @(negedge clock);
      #2;
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) clientQ[i].delete();
      expQ.delete();
      #1;
      checkResetValues("midframe");
      @(negedge clock);
      #2;
      reset = 1'b0;
      applyStimulus(0, 8'hC0, 1, 1'b1);
      applyStimulus(3, 8'hD0, 1, 1'b1);
      waitDrain("after_reset");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Hard stop in case something above never returns
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte-stream clients. A client wins the transmitter for a whole packet, from its first byte through the byte flagged `req_last`. The arbiter launches each byte with a one-cycle `tx_start` and tracks the transmitter's `tx_busy` so that bytes never overlap. It sits between the on-chip message sources and the single `uart_tx` instance, the transmit-side counterpart of the receive FSM.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of clients, ≥2.
- `DATA_W`, default 8: byte width.
- `TIMEOUT`, default 1024: idle cycles mid-packet before a grant is revoked, ≥1.

Ports (reset is `reset`, asynchronous, active-high; clock is `clock`):
- `clock`  in  1  system clock
- `reset`  in  1  async active-high reset
- `req_valid`  in  NUM_REQ  client i has a byte pending
- `req_data`  in  NUM_REQ×DATA_W  packed; client i occupies bits [i*DATA_W +: DATA_W]
- `req_last`  in  NUM_REQ  pending byte is the last of its packet
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: byte consumed
- `tx_data`  out  DATA_W  byte to transmitter, registered
- `tx_start`  out  1  one-cycle launch pulse
- `tx_busy`  in  1  transmitter shifting a frame
- `grant_active`  out  1  a packet grant is held
- `grant_id`  out  $clog2(NUM_REQ)  index of current/last grantee

## Operation
- States: IDLE, HOLD, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - When `tx_busy`=0 and any `req_valid` is set, pick the first requester scanning from `ptr+1` modulo `NUM_REQ`.
  - Register `grant_id`, set `grant_active`, clear the timeout counter, and go to HOLD.
  - `ptr` resets to `NUM_REQ-1`, so client 0 wins first.
- HOLD:
  - If `req_valid[grant_id]`: capture `tx_data` ← that client's data and `last_q` ← `req_last[grant_id]`, then go to ISSUE.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT-1`: clear `grant_active`, set `ptr` ← `grant_id`, and go to IDLE. No byte is consumed.
- ISSUE (one cycle): `tx_start`=1 and `req_ready[grant_id]`=1, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: stay until `tx_busy`=0, then:
  - if `last_q`: clear `grant_active`, set `ptr` ← `grant_id`, go to IDLE;
  - otherwise return to HOLD with the timeout counter cleared.
- Client contract: hold `req_valid`/`req_data`/`req_last` stable until `req_ready` pulses. Non-granted clients' inputs are ignored.
- Timeout counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values: `tx_start`=0, `req_ready`=0, `tx_data`=0, `grant_active`=0, `grant_id`=0, state=IDLE, `ptr`=`NUM_REQ-1`.
- Reset mid-packet aborts immediately. A `tx_start` pulse is never emitted on the cycle reset deasserts.
- `req_valid` rising in IDLE at cycle 0 gives grant at cycle 1 (HOLD) and `tx_start`/`req_ready` at cycle 2, when data is already valid at cycle 1.
- Inter-byte latency: `tx_busy` falls at cycle n, HOLD at n+1, `tx_start` at n+2.
- All outputs are registered.
- `grant_id` holds its value after release until the next grant.
- Simultaneous requests: exactly one grant, by rotating priority. A client that just finished has lowest priority next.
- `tx_busy` already high in IDLE blocks arbitration.
- A single-byte packet (`req_last` on the first byte) releases after one frame.

## Structure
- `uart_pkg` holds the `arb_state_t` enum (the five states above), alongside the existing rx control-point enums.
- The datapath is registers plus the one-hot `req_ready` decode.
- One sub-module, `rr_pick`, is natural: a combinational rotating-priority encoder. Inputs are the request vector and `ptr`; outputs are `found` and the index.

## Test plan
- Single client: client 0 sends bytes 0x41, 0x42 (last) → two `tx_start` pulses with `tx_data` 0x41 then 0x42, the second 2 cycles after `tx_busy` falls. `grant_active` drops after the second frame.
- Contention: clients 0 and 2 each send 3-byte packets simultaneously → client 0's packet is sent fully, then client 2's. No interleaving.
- Fairness: clients 1 and 3 request continuously with 1-byte packets → grants alternate 1, 3, 1, 3.
- Timeout: `TIMEOUT`=8; client 1 sends one non-last byte and then drops `req_valid` → grant released exactly 8 cycles after entering HOLD. Client 2, waiting, is then granted with no extra `req_ready` to client 1.
- Busy blocking: hold `tx_busy`=1 while client 0 requests → no grant until `tx_busy` falls. Grant follows on the next cycle.
- Reset mid-frame: assert `reset` in WAIT_DONE → all outputs return to reset values, and client 0 is granted first afterwards.
